// File: rtl/mst_read_arbiter.sv
// ============================================================================
// Module      : mst_read_arbiter
// Description : Two-requester single-word read arbiter driving a bus master
//               read port (CMD/DATA handshake, timeout abort, one-cycle rsp).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mst_read_arbiter #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] ip2bus_mst_addr,
    output logic [11:0] ip2bus_mst_length,
    input  logic [31:0] ip2bus_mstrd_d,
    output logic [4:0]  ip2bus_inputs,
    input  logic [5:0]  ip2bus_otputs,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Counter value of the last CMD/DATA cycle allowed before abort.
    localparam logic [11:0] C_TIMEOUT_LAST = 12'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mstread_req_q, mstread_req_d;
    logic        mst_type_q, mst_type_d;
    logic        dst_rdy_n_q, dst_rdy_n_d;
    logic        busy_q, busy_d;

    logic        w_cmd_ack;
    logic        w_src_rdy;
    logic        w_timeout;
    logic        w_go_resp;
    logic        w_go_err;
    logic        w_unused_otputs;

    assign w_cmd_ack       = ip2bus_otputs[0];
    assign w_src_rdy       = ~ip2bus_otputs[3];
    assign w_timeout       = (cnt_q == C_TIMEOUT_LAST);
    assign w_unused_otputs = ^{ip2bus_otputs[5:4], ip2bus_otputs[2:1]};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 2'b00;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        w_go_resp    = 1'b0;
        w_go_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    // A tie goes to whoever was not served last.
                    grant_d = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    addr_d  = grant_d ? req_addr1 : req_addr0;
                    cnt_d   = 12'd0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_d = cnt_q + 12'd1;
                if (w_timeout) begin
                    w_go_resp = 1'b1;
                    w_go_err  = 1'b1;
                end else if (w_cmd_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 12'd1;
                if (w_src_rdy) begin
                    w_go_resp = 1'b1;
                end else if (w_timeout) begin
                    w_go_resp = 1'b1;
                    w_go_err  = 1'b1;
                end
            end
            default: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
        endcase

        if (w_go_resp) begin
            state_d     = ST_RESP;
            rsp_valid_d = grant_q ? 2'b10 : 2'b01;
            rsp_err_d   = w_go_err;
            rsp_data_d  = w_go_err ? 32'd0 : ip2bus_mstrd_d;
        end

        // Bus-facing strobes are registered from the state being entered.
        mstread_req_d = (state_d == ST_CMD);
        mst_type_d    = (state_d == ST_CMD);
        dst_rdy_n_d   = ~((state_d == ST_CMD) || (state_d == ST_DATA));
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            addr_q        <= 32'd0;
            cnt_q         <= 12'd0;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= 32'd0;
            rsp_err_q     <= 1'b0;
            mstread_req_q <= 1'b0;
            mst_type_q    <= 1'b0;
            dst_rdy_n_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            mstread_req_q <= mstread_req_d;
            mst_type_q    <= mst_type_d;
            dst_rdy_n_q   <= dst_rdy_n_d;
            busy_q        <= busy_d;
        end
    end

    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_err           = rsp_err_q;
    assign ip2bus_mst_addr   = addr_q;
    assign ip2bus_mst_length = 12'd4;
    assign ip2bus_inputs     = {2'b00, dst_rdy_n_q, mst_type_q, mstread_req_q};
    assign busy              = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mst_read_arbiter.sv
// ============================================================================
// Module      : tb_mst_read_arbiter
// Description : Self-checking bench for mst_read_arbiter: vector table,
//               reset/idle corner sequences and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mst_read_arbiter;

    localparam int TO = 15;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] ip2bus_mst_addr;
    logic [11:0] ip2bus_mst_length;
    logic [31:0] ip2bus_mstrd_d;
    logic [4:0]  ip2bus_inputs;
    logic [5:0]  ip2bus_otputs;
    logic        busy;

    logic        cmd_ack;
    logic        src_rdy_n;
    logic [3:0]  junk;

    int n_cmp;
    int n_bad;
    logic ref_last;

    assign ip2bus_otputs = {junk[3:2], src_rdy_n, junk[1:0], cmd_ack};

    mst_read_arbiter #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_addr0         (req_addr0),
        .req_addr1         (req_addr1),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err),
        .ip2bus_mst_addr   (ip2bus_mst_addr),
        .ip2bus_mst_length (ip2bus_mst_length),
        .ip2bus_mstrd_d    (ip2bus_mstrd_d),
        .ip2bus_inputs     (ip2bus_inputs),
        .ip2bus_otputs     (ip2bus_otputs),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: ack_at = CMD cycle index carrying cmd_ack (-1 never),
    // src_at = DATA cycle index carrying src_rdy_n=0 (-1 never),
    // k = cycle index (from CMD entry) where the rsp pulse is expected.
    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        int          ack_at;
        int          src_at;
        int          drop_k;
        logic [1:0]  drop_mask;
        logic [31:0] data;
        logic        g;
        logic        err;
        int          k;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic [1:0] req, input logic [31:0] a0,
                                input logic [31:0] a1, input int ack_at,
                                input int src_at, input int drop_k,
                                input logic [1:0] dm, input logic [31:0] d,
                                input logic g, input logic err, input int k);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.ack_at = ack_at; v.src_at = src_at;
        v.drop_k = drop_k; v.drop_mask = dm; v.data = d; v.g = g; v.err = err;
        v.k = k;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_data"}, rsp_data, 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " mst_addr"}, ip2bus_mst_addr, 32'd0);
        chk({tag, " ip2bus_inputs"}, 32'(ip2bus_inputs), 32'h4);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " length"}, 32'(ip2bus_mst_length), 32'd4);
    endtask

    task automatic idle_cycle(input string tag, input logic [31:0] hold_d, input logic hold_e);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle ip2bus_inputs"}, 32'(ip2bus_inputs), 32'h4);
        chk({tag, " idle rsp_data hold"}, rsp_data, hold_d);
        chk({tag, " idle rsp_err hold"}, 32'(rsp_err), 32'(hold_e));
    endtask

    // Precondition: called at a negedge with the DUT idle.
    task automatic run_txn(input vec_t v, input int id);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          cap;
        logic        in_data;
        string       tag;
        tag      = $sformatf("t%0d", id);
        exp_addr = v.g ? v.a1 : v.a0;
        exp_data = v.err ? 32'd0 : v.data;
        cap      = (v.ack_at < 0 || v.src_at < 0) ? -1 : v.ack_at + 1 + v.src_at;
        req_valid = v.req;
        req_addr0 = v.a0;
        req_addr1 = v.a1;
        cmd_ack   = 1'($urandom);
        src_rdy_n = 1'($urandom);
        junk      = 4'($urandom);
        ip2bus_mstrd_d = $urandom;
        for (int k = 0; k <= v.k; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_data = (v.ack_at >= 0) && (k > v.ack_at);
            chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s k%0d mst_addr", tag, k), ip2bus_mst_addr, exp_addr);
            chk($sformatf("%s k%0d length", tag, k), 32'(ip2bus_mst_length), 32'd4);
            if (k < v.k) begin
                chk($sformatf("%s k%0d rsp_valid", tag, k), 32'(rsp_valid), 32'd0);
                chk($sformatf("%s k%0d ip2bus_inputs", tag, k), 32'(ip2bus_inputs),
                    in_data ? 32'h0 : 32'h3);
                if (k == v.drop_k) req_valid = req_valid & ~v.drop_mask;
                cmd_ack   = (k == v.ack_at) ? 1'b1 : (in_data ? 1'($urandom) : 1'b0);
                src_rdy_n = in_data ? (k != cap) : 1'($urandom);
                ip2bus_mstrd_d = (k == cap) ? v.data : $urandom;
                junk      = 4'($urandom);
            end else begin
                chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid), v.g ? 32'h2 : 32'h1);
                chk($sformatf("%s rsp_data", tag), rsp_data, exp_data);
                chk($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(v.err));
                chk($sformatf("%s resp ip2bus_inputs", tag), 32'(ip2bus_inputs), 32'h4);
            end
        end
        req_valid = 2'b00;
        cmd_ack   = 1'($urandom);
        src_rdy_n = 1'($urandom);
        idle_cycle(tag, exp_data, v.err);
        ref_last = v.g;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   mode;
        n_cmp = 0;
        n_bad = 0;
        ref_last = 1'b1;
        reset_n = 1'b0;
        req_valid = 2'b00;
        req_addr0 = 32'd0;
        req_addr1 = 32'd0;
        cmd_ack = 1'b0;
        src_rdy_n = 1'b1;
        junk = 4'd0;
        ip2bus_mstrd_d = 32'd0;

        tbl[0]  = mk(2'b11, 32'h1000, 32'h2000, 0, 0, -1, 2'b00, 32'h11111111, 1'b0, 1'b0, 2);
        tbl[1]  = mk(2'b11, 32'h1004, 32'h2004, 1, 1, -1, 2'b00, 32'h22222222, 1'b1, 1'b0, 4);
        tbl[2]  = mk(2'b11, 32'h1008, 32'h2008, 2, 0, -1, 2'b00, 32'h33333333, 1'b0, 1'b0, 4);
        tbl[3]  = mk(2'b11, 32'h100C, 32'h200C, 0, 2, -1, 2'b00, 32'h44444444, 1'b1, 1'b0, 4);
        tbl[4]  = mk(2'b01, 32'h200000, 32'h0, 1, 0, -1, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 3);
        tbl[5]  = mk(2'b01, 32'h3000, 32'h4000, -1, -1, -1, 2'b00, 32'h55555555, 1'b0, 1'b1, TO);
        tbl[6]  = mk(2'b11, 32'h5000, 32'h6000, 0, 1, 0, 2'b10, 32'h66666666, 1'b1, 1'b0, 3);
        tbl[7]  = mk(2'b10, 32'h7000, 32'h8000, 3, 3, -1, 2'b00, 32'h77777777, 1'b1, 1'b0, 8);
        tbl[8]  = mk(2'b01, 32'h9000, 32'hA000, 0, 0, 1, 2'b01, 32'h88888888, 1'b0, 1'b0, 2);
        tbl[9]  = mk(2'b10, 32'hB000, 32'hC000, 2, -1, -1, 2'b00, 32'h99999999, 1'b1, 1'b1, TO);
        tbl[10] = mk(2'b11, 32'hD000, 32'hE000, 5, 7, -1, 2'b00, 32'hCAFEF00D, 1'b0, 1'b0, 14);

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(tbl[i], i);

        // Reset asserted while in DATA: aborts without a response.
        req_valid = 2'b01;
        req_addr0 = 32'h00ABCD00;
        cmd_ack = 1'b0;
        src_rdy_n = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("pre-reset in DATA", 32'(ip2bus_inputs), 32'h0);
        cmd_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async reset");
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("reset no rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ref_last = 1'b1;
        run_txn(mk(2'b11, 32'h111, 32'h222, 0, 0, -1, 2'b00, 32'h0BADCAFE, 1'b0, 1'b0, 2), 100);
        run_txn(mk(2'b10, 32'h333, 32'h444, 1, 1, -1, 2'b00, 32'h12345678, 1'b1, 1'b0, 4), 101);

        // Handshake strobes while idle must be ignored.
        req_valid = 2'b00;
        cmd_ack = 1'b1;
        src_rdy_n = 1'b0;
        for (int i = 0; i < 3; i++) idle_cycle("idle-noise", 32'h12345678, 1'b0);
        cmd_ack = 1'b0;
        src_rdy_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            v.req = 2'($urandom_range(1, 3));
            v.a0 = $urandom;
            v.a1 = $urandom;
            v.data = $urandom;
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                v.ack_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
                v.src_at = -1;
                v.err = 1'b1;
                v.k = TO;
            end else begin
                v.ack_at = int'($urandom_range(0, 5));
                v.src_at = int'($urandom_range(0, 5));
                v.err = 1'b0;
                v.k = v.ack_at + v.src_at + 2;
            end
            v.drop_k = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
            v.drop_mask = 2'($urandom_range(1, 3));
            v.g = (v.req == 2'b11) ? ~ref_last : v.req[1];
            run_txn(v, 200 + i);
            repeat ($urandom_range(0, 2)) idle_cycle("gap", v.err ? 32'd0 : v.data, v.err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
